// File: rtl/imem_loader.sv
// Framed byte stream (count, words, checksum) to 16-bit instruction-memory writes; holds the CPU while loading.
// mem_we 1 cycle after each DATA_LO handshake; byte_ready registered, high in every byte-consuming state, never stalls on writes.
module imem_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [10:0]           words_written
);
   typedef enum logic [2:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                state;
   logic [15:0]           count;
   logic [7:0]            checksum;
   logic [7:0]            data_hi;
   logic [ADDR_WIDTH-1:0] addr;

   logic        xfer;
   logic [15:0] cnt_full;
   logic [10:0] words_next;

   assign xfer       = byte_valid && byte_ready;
   assign cnt_full   = {count[15:8], byte_in};
   assign words_next = words_written + 11'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         count         <= '0;
         checksum      <= '0;
         data_hi       <= '0;
         addr          <= '0;
         byte_ready    <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         cpu_hold      <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         words_written <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state         <= S_CNT_HI;
                  byte_ready    <= 1'b1;
                  cpu_hold      <= 1'b1;
                  done          <= 1'b0;
                  error         <= 1'b0;
                  words_written <= '0;
                  checksum      <= '0;
                  addr          <= '0;
               end
            end
            S_CNT_HI: begin
               if (xfer) begin
                  count[15:8] <= byte_in;
                  state       <= S_CNT_LO;
               end
            end
            S_CNT_LO: begin
               if (xfer) begin
                  count[7:0] <= byte_in;
                  if (cnt_full > 16'(MAX_WORDS)) begin
                     state      <= S_ERR;
                     byte_ready <= 1'b0;
                     error      <= 1'b1;
                  end else if (cnt_full == 16'd0) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (xfer) begin
                  data_hi  <= byte_in;
                  checksum <= checksum + byte_in;
                  state    <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (xfer) begin
                  checksum      <= checksum + byte_in;
                  mem_we        <= 1'b1;
                  mem_wdata     <= {data_hi, byte_in};
                  mem_addr      <= addr;
                  addr          <= addr + ADDR_ONE;
                  words_written <= words_next;
                  state         <= ({5'd0, words_next} == count) ? S_CHECK : S_DATA_HI;
               end
            end
            S_CHECK: begin
               if (xfer) begin
                  byte_ready <= 1'b0;
                  if (byte_in == checksum) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     // hold stays asserted so a corrupt image never runs
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: expected memory writes are queued as words are sent and popped on mem_we.
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [10:0] words_written;

   int n_total = 0;
   int n_pass  = 0;

   logic [25:0] exp_q[$];
   logic [15:0] frame_words[1024];
   logic [7:0]  chk_acc;

   imem_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024)) dut (
      .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
      .done(done), .error(error), .words_written(words_written)
   );

   always #5 clk = ~clk;

   // scoreboard: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: got addr=%0d data=%04h, required no write", mem_addr, mem_wdata);
         end else begin
            logic [25:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e)
               $display("FAIL write: got addr=%0d data=%04h, required addr=%0d data=%04h",
                        mem_addr, mem_wdata, e[25:16], e[15:0]);
            else
               n_pass++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc;
      int n;
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      byte_in    = b;
      byte_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
         @(negedge clk);
         acc = byte_ready;
         @(posedge clk); #1;
         n++;
      end
      byte_valid = 1'b0;
      n_total++;
      if (!acc) $display("FAIL byte_accept: byte %02h byte_ready=0 for %0d cycles, required 1", b, n);
      else      n_pass++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_word(input int idx, input int maxgap);
      logic [15:0] w;
      logic [9:0]  a;
      w = frame_words[idx];
      a = idx[9:0];
      send_byte(w[15:8], int'($urandom_range(maxgap, 0)));
      chk_acc = chk_acc + w[15:8] + w[7:0];
      exp_q.push_back({a, w});
      send_byte(w[7:0], int'($urandom_range(maxgap, 0)));
      n_total++;
      if (mem_we !== 1'b1 || words_written !== 11'(idx + 1))
         $display("FAIL write_latency: word %0d mem_we=%b words_written=%0d, required 1 and %0d",
                  idx, mem_we, words_written, idx + 1);
      else
         n_pass++;
   endtask

   task automatic send_frame(input int n, input bit corrupt, input int maxgap, input bit poke);
      logic [15:0] nn;
      nn = n[15:0];
      chk_acc = 8'd0;
      send_byte(nn[15:8], int'($urandom_range(maxgap, 0)));
      send_byte(nn[7:0], int'($urandom_range(maxgap, 0)));
      for (int i = 0; i < n; i++) begin
         send_word(i, maxgap);
         if (poke && (i % 256) == 100) pulse_start();
      end
      send_byte(corrupt ? chk_acc - 8'd1 : chk_acc, int'($urandom_range(maxgap, 0)));
   endtask

   task automatic do_start();
      pulse_start();
      n_total++;
      if ({cpu_hold, byte_ready, done, error, words_written} !== {4'b1100, 11'd0})
         $display("FAIL start: hold=%b rdy=%b done=%b err=%b words=%0d, required 1 1 0 0 0",
                  cpu_hold, byte_ready, done, error, words_written);
      else
         n_pass++;
   endtask

   task automatic load_three();
      frame_words[0] = 16'h1234;
      frame_words[1] = 16'hABCD;
      frame_words[2] = 16'h0001;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written} !== 41'd0)
         $display("FAIL reset_values: rdy=%b we=%b addr=%0d wdata=%04h hold=%b done=%b err=%b words=%0d, required all 0",
                  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written);
      else
         n_pass++;
      reset = 1'b0;
      @(posedge clk); #1;
      n_total++;
      if (byte_ready !== 1'b0 || cpu_hold !== 1'b0)
         $display("FAIL idle: rdy=%b hold=%b, required 0 0", byte_ready, cpu_hold);
      else
         n_pass++;
   endtask

   task automatic test_good_frame();
      load_three();
      do_start();
      send_frame(3, 1'b0, 0, 1'b0);
      n_total++;
      if ({done, error, cpu_hold, byte_ready, words_written} !== {4'b1000, 11'd3} || exp_q.size() != 0)
         $display("FAIL good_frame: done=%b err=%b hold=%b rdy=%b words=%0d pending=%0d, required 1 0 0 0 3 0",
                  done, error, cpu_hold, byte_ready, words_written, exp_q.size());
      else
         n_pass++;
   endtask

   task automatic test_bad_checksum();
      load_three();
      do_start();
      send_frame(3, 1'b1, 0, 1'b0);
      n_total++;
      if ({done, error, cpu_hold, byte_ready, words_written} !== {4'b0110, 11'd3} || exp_q.size() != 0)
         $display("FAIL bad_checksum: done=%b err=%b hold=%b rdy=%b words=%0d pending=%0d, required 0 1 1 0 3 0",
                  done, error, cpu_hold, byte_ready, words_written, exp_q.size());
      else
         n_pass++;
   endtask

   task automatic test_zero_count();
      do_start();
      send_frame(0, 1'b0, 0, 1'b0);
      n_total++;
      if ({done, error, cpu_hold, byte_ready, words_written} !== {4'b1000, 11'd0})
         $display("FAIL zero_count: done=%b err=%b hold=%b rdy=%b words=%0d, required 1 0 0 0 0",
                  done, error, cpu_hold, byte_ready, words_written);
      else
         n_pass++;
   endtask

   task automatic test_bad_count();
      do_start();
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      n_total++;
      if ({done, error, cpu_hold, byte_ready, words_written} !== {4'b0110, 11'd0})
         $display("FAIL bad_count: done=%b err=%b hold=%b rdy=%b words=%0d, required 0 1 1 0 0",
                  done, error, cpu_hold, byte_ready, words_written);
      else
         n_pass++;
   endtask

   task automatic test_gaps();
      load_three();
      do_start();
      send_frame(3, 1'b0, 5, 1'b0);
      n_total++;
      if ({done, error, cpu_hold, byte_ready, words_written} !== {4'b1000, 11'd3} || exp_q.size() != 0)
         $display("FAIL gaps: done=%b err=%b hold=%b rdy=%b words=%0d pending=%0d, required 1 0 0 0 3 0",
                  done, error, cpu_hold, byte_ready, words_written, exp_q.size());
      else
         n_pass++;
   endtask

   task automatic test_reset_mid_load();
      load_three();
      do_start();
      chk_acc = 8'd0;
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      send_word(0, 0);
      send_word(1, 0);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      n_total++;
      if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written} !== 41'd0)
         $display("FAIL async_reset: rdy=%b we=%b addr=%0d wdata=%04h hold=%b done=%b err=%b words=%0d, required all 0",
                  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written);
      else
         n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      do_start();
      send_frame(3, 1'b0, 0, 1'b0);
      n_total++;
      if ({done, error, cpu_hold, words_written} !== {3'b100, 11'd3} || exp_q.size() != 0)
         $display("FAIL reload: done=%b err=%b hold=%b words=%0d pending=%0d, required 1 0 0 3 0",
                  done, error, cpu_hold, words_written, exp_q.size());
      else
         n_pass++;
   endtask

   task automatic test_max_frame();
      for (int i = 0; i < 1024; i++) frame_words[i] = 16'(i);
      do_start();
      send_frame(1024, 1'b0, 0, 1'b1);
      n_total++;
      if ({done, error, cpu_hold, words_written} !== {3'b100, 11'd1024} || exp_q.size() != 0)
         $display("FAIL max_frame: done=%b err=%b hold=%b words=%0d pending=%0d, required 1 0 0 1024 0",
                  done, error, cpu_hold, words_written, exp_q.size());
      else
         n_pass++;
      n_total++;
      if (mem_addr !== 10'd1023 || mem_wdata !== 16'd1023)
         $display("FAIL max_last_write: addr=%0d data=%04h, required addr=1023 data=03ff", mem_addr, mem_wdata);
      else
         n_pass++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_zero_count();
      test_bad_count();
      test_gaps();
      test_reset_mid_load();
      test_max_frame();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
